// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: picks the next fetch PC (increment, redirect or hold),
// drives the instruction-memory request and produces stall_f / flush_d for the IF-ID register.
module fetch_sequencer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter int               STEP       = 4,
    parameter int               ALIGN_BITS = 2,
    parameter int               MAX_WAIT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_ready,
    input  logic             stall_d,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             halt,
    input  logic             resume,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] pc_f,
    output logic             stall_f,
    output logic             flush_d,
    output logic             halted,
    output logic             fetch_err,
    output logic [15:0]      redirect_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    // Handshake: imem_req high means imem_addr is presented this cycle; the
    // address counts as fetched on a rising edge where imem_req and imem_ready
    // are both high, otherwise the same address is presented again.

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              misaligned;

    assign misaligned = (branch_target[ALIGN_BITS-1:0] != '0);
    assign wait_next  = wait_cnt + 1'b1;

    assign imem_addr = pc_f;
    assign imem_req  = (state == FETCH);
    assign halted    = (state == HALTED);
    assign fsm_state = state;

    always_comb begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        if (state == FETCH) begin
            if (branch_taken) begin
                // A bad target leaves the PC where it is, so the IF-ID hold stays on.
                stall_f = misaligned;
                flush_d = 1'b1;
            end else if (halt) begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end else if (stall_d) begin
                stall_f = 1'b1;
                flush_d = 1'b0;
            end else if (!imem_ready) begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end else begin
                stall_f = 1'b0;
                flush_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BOOT;
            pc_f         <= RESET_VEC;
            wait_cnt     <= '0;
            redirect_cnt <= '0;
            fetch_err    <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    if (branch_taken && misaligned) begin
                        state     <= ERROR;
                        fetch_err <= 1'b1;
                    end else if (branch_taken) begin
                        pc_f         <= branch_target;
                        redirect_cnt <= redirect_cnt + 16'd1;
                        wait_cnt     <= '0;
                    end else if (halt) begin
                        state <= HALTED;
                    end else if (stall_d) begin
                        state <= FETCH;
                    end else if (!imem_ready) begin
                        wait_cnt <= wait_next;
                        if (wait_next == WAIT_W'(MAX_WAIT)) begin
                            state     <= ERROR;
                            fetch_err <= 1'b1;
                        end
                    end else begin
                        pc_f     <= pc_f + WIDTH'(STEP);
                        wait_cnt <= '0;
                    end
                end
                HALTED: begin
                    if (resume) state <= FETCH;
                end
                ERROR: state <= ERROR;
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of per-cycle vectors plus hand sequences
// for wait timeout, mid-wait reset, halt/resume and PC wrap-around.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic        stall_d;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt;
    logic        resume;

    logic        imem_req, stall_f, flush_d, halted, fetch_err;
    logic [31:0] imem_addr, pc_f;
    logic [15:0] redirect_cnt;
    logic [1:0]  fsm_state;

    logic        w_req, w_stall, w_flush, w_halted, w_err;
    logic [31:0] w_addr, w_pc;
    logic [15:0] w_cnt;
    logic [1:0]  w_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall_d(stall_d),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .resume(resume), .imem_req(imem_req), .imem_addr(imem_addr),
        .pc_f(pc_f), .stall_f(stall_f), .flush_d(flush_d), .halted(halted),
        .fetch_err(fetch_err), .redirect_cnt(redirect_cnt), .fsm_state(fsm_state)
    );

    fetch_sequencer #(.RESET_VEC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall_d(stall_d),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .resume(resume), .imem_req(w_req), .imem_addr(w_addr),
        .pc_f(w_pc), .stall_f(w_stall), .flush_d(w_flush), .halted(w_halted),
        .fetch_err(w_err), .redirect_cnt(w_cnt), .fsm_state(w_state)
    );

    typedef struct {
        logic        rst, rdy, stl, br;
        logic [31:0] tgt;
        logic        hlt, res;
        logic [31:0] e_pc;
        logic        e_stall, e_flush, e_req, e_halt, e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b0; stall_d = 1'b0; branch_taken = 1'b0;
        branch_target = '0; halt = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();

        //        rst  rdy  stl  br   tgt           hlt  res  pc            st   fl   req  hl   er   cnt
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0,16'd0};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0,16'd0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,16'd0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h4,        1'b0,1'b0,1'b1,1'b0,1'b0,16'd0};
        vecs[4]  = '{1'b0,1'b1,1'b1,1'b1,32'h40,      1'b0,1'b0,32'h8,        1'b0,1'b1,1'b1,1'b0,1'b0,16'd0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h40,       1'b0,1'b0,1'b1,1'b0,1'b0,16'd1};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h44,       1'b1,1'b0,1'b1,1'b0,1'b0,16'd1};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h44,       1'b1,1'b1,1'b1,1'b0,1'b0,16'd1};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h44,       1'b0,1'b0,1'b1,1'b0,1'b0,16'd1};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b1,1'b0,32'h48,       1'b1,1'b1,1'b1,1'b0,1'b0,16'd1};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b1,32'h80,      1'b0,1'b0,32'h48,       1'b1,1'b1,1'b0,1'b1,1'b0,16'd1};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b1,1'b1,32'h48,       1'b1,1'b1,1'b0,1'b1,1'b0,16'd1};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h48,       1'b0,1'b0,1'b1,1'b0,1'b0,16'd1};
        vecs[13] = '{1'b0,1'b1,1'b0,1'b1,32'h42,      1'b0,1'b0,32'h4C,       1'b1,1'b1,1'b1,1'b0,1'b0,16'd1};
        vecs[14] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h4C,       1'b1,1'b1,1'b0,1'b0,1'b1,16'd1};
        vecs[15] = '{1'b1,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h4C,       1'b1,1'b1,1'b0,1'b0,1'b1,16'd1};
        vecs[16] = '{1'b0,1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,1'b1,1'b0,1'b0,1'b0,16'd0};

        for (int i = 0; i < 17; i++) begin
            reset = vecs[i].rst; imem_ready = vecs[i].rdy; stall_d = vecs[i].stl;
            branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
            halt = vecs[i].hlt; resume = vecs[i].res;
            @(negedge clk);
            chk($sformatf("v%0d pc_f", i),      pc_f,          vecs[i].e_pc);
            chk($sformatf("v%0d imem_addr", i), imem_addr,     vecs[i].e_pc);
            chk($sformatf("v%0d stall_f", i),   32'(stall_f),  32'(vecs[i].e_stall));
            chk($sformatf("v%0d flush_d", i),   32'(flush_d),  32'(vecs[i].e_flush));
            chk($sformatf("v%0d imem_req", i),  32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d halted", i),    32'(halted),   32'(vecs[i].e_halt));
            chk($sformatf("v%0d fetch_err", i), 32'(fetch_err),32'(vecs[i].e_err));
            chk($sformatf("v%0d redir_cnt", i), 32'(redirect_cnt), 32'(vecs[i].e_cnt));
            tick();
        end

        // Memory wait: 14 low cycles survive, 15 trip the error, which then sticks.
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat (14) tick();
        chk("wait14 err", 32'(fetch_err), 32'd0);
        chk("wait14 pc", pc_f, 32'h0);
        imem_ready = 1'b1;
        tick();
        chk("wait14 advance", pc_f, 32'h4);
        imem_ready = 1'b0;
        repeat (15) tick();
        chk("wait15 err", 32'(fetch_err), 32'd1);
        imem_ready = 1'b1;
        repeat (10) tick();
        chk("err sticky", 32'(fetch_err), 32'd1);
        chk("err pc hold", pc_f, 32'h4);
        chk("err no req", 32'(imem_req), 32'd0);
        chk("err state", 32'(fsm_state), 32'd3);

        // Reset in the middle of a wait must clear the wait counter.
        do_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat (5) tick();
        do_reset();
        chk("midwait pc", pc_f, 32'h0);
        chk("midwait boot", 32'(fsm_state), 32'd0);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat (14) tick();
        chk("midwait cnt cleared", 32'(fetch_err), 32'd0);
        imem_ready = 1'b1;
        tick();
        chk("midwait advance", pc_f, 32'h4);

        // Halt at 0x10, ignore redirects while halted, resume at the same PC.
        do_reset();
        imem_ready = 1'b1;
        repeat (5) tick();
        chk("pre-halt pc", pc_f, 32'h10);
        halt = 1'b1;
        #1;
        chk("halt stall_f", 32'(stall_f), 32'd1);
        chk("halt flush_d", 32'(flush_d), 32'd1);
        tick();
        halt = 1'b0; branch_taken = 1'b1; branch_target = 32'h80; stall_d = 1'b1;
        repeat (3) tick();
        chk("halted flag", 32'(halted), 32'd1);
        chk("halted req", 32'(imem_req), 32'd0);
        chk("halted pc", pc_f, 32'h10);
        chk("halted no redirect", 32'(redirect_cnt), 32'd0);
        branch_taken = 1'b0; stall_d = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume halted", 32'(halted), 32'd0);
        chk("resume req", 32'(imem_req), 32'd1);
        chk("resume addr", imem_addr, 32'h10);
        tick();
        chk("resume advance", pc_f, 32'h14);

        // Wrap-around from the top of the address space.
        do_reset();
        chk("wrap reset vec", w_pc, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        tick();
        chk("wrap first fetch", w_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap to zero", w_pc, 32'h0);
        chk("wrap no err", 32'(w_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
